alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- ID/EX pipeline stage that produces the 4-bit ALU operation code and both ALU operands for the MIPS datapath ALU.
- Decodes MIPS opcode/funct into the ALU OP encoding and selects and prepares the operands: shamt placement, immediate extension, shift-amount masking.
- Registers the result behind a valid/ready handshake, with stall and flush.
- Sits between register-file read (ID) and the ALU (EX).

Parameters:
- CNT_W, 16, width of the issued-instruction and illegal-instruction counters.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  ID presents an instruction.
- in_ready  out  1  stage can accept this cycle.
- opcode  in  6  instr[31:26].
- funct  in  6  instr[5:0].
- shamt  in  5  instr[10:6].
- rt_idx  in  5  instr[20:16].
- rd_idx  in  5  instr[15:11].
- imm16  in  16  instr[15:0].
- rs_data  in  32  register file read port A.
- rt_data  in  32  register file read port B.
- flush  in  1  kill held and incoming instruction.
- ex_valid  out  1  EX outputs are valid.
- ex_ready  in  1  EX consumes this cycle.
- alu_op  out  4  ALU OP code.
- alu_in1  out  32  ALU In1.
- alu_in2  out  32  ALU In2.
- dest_reg  out  5  write-back register index.
- reg_write  out  1  write-back enable.
- illegal  out  1  undecodable instruction.
- issued_cnt  out  CNT_W  count of EX transfers (ex_valid & ex_ready).
- illegal_cnt  out  CNT_W  count of transferred illegal instructions.

Behaviour:
- ALU OP encoding, fixed:
  - 0000 add; 0001 sub; 0011 and; 0100 nor; 0101 or; 0110 xor.
  - 0111 In2<<In1; 1000 In1<<In2; 1001 In2>>In1 (logical); 1010 In1>>In2.
  - 1110 signed slt; 1111 unsigned sltu. Any other code yields result 0.
- R-type (opcode 000000); dest=rd_idx; default in1=rs_data, in2=rt_data:
  - funct 20/21 -> 0000; 22/23 -> 0001.
  - funct 24 -> 0011; 25 -> 0101; 26 -> 0110; 27 -> 0100.
  - funct 2A -> 1110; 2B -> 1111.
  - funct 00 sll -> 0111, in1={27'b0,shamt}; 02 srl -> 1001, in1={27'b0,shamt}.
  - funct 04 sllv -> 0111, in1={27'b0,rs_data[4:0]}; 06 srlv -> 1001, in1={27'b0,rs_data[4:0]}.
- I-type; dest=rt_idx; in1=rs_data:
  - 08/09 -> 0000, in2=sign-ext imm16.
  - 0A -> 1110, sign-ext; 0B -> 1111, sign-ext.
  - 0C -> 0011, zero-ext; 0D -> 0101, zero-ext; 0E -> 0110, zero-ext.
  - 0F lui -> 1000, in1={16'b0,imm16}, in2=32'd16.
- Any other opcode/funct: alu_op=0010, in1=in2=0, reg_write=0, illegal=1.
- reg_write=1 for legal instructions with dest_reg!=0, else 0.
- Handshake:
  - in_ready = !flush & (!ex_valid | ex_ready), combinational.
  - load = in_valid & in_ready; decoded values are registered on load.
  - Latency: 1 cycle from acceptance to ex_valid.
  - Full throughput: back-to-back loads when ex_ready stays high.
  - ex_valid next = flush ? 0 : load ? 1 : (ex_ready ? 0 : ex_valid).
  - While ex_valid & !ex_ready, all EX outputs hold stable.
- Flush:
  - Takes priority over load and hold; the held instruction is dropped and not counted.
  - Incoming is not accepted (in_ready=0).
  - Payload registers may keep stale values; only ex_valid is cleared.
- Counters:
  - issued_cnt increments on ex_valid & ex_ready & !flush.
  - illegal_cnt increments on the same condition when illegal=1.
  - Both wrap modulo 2^CNT_W.
- Reset (sync, highest priority, also mid-transfer):
  - ex_valid=0, alu_op=0000, alu_in1=alu_in2=0, dest_reg=0, reg_write=0, illegal=0, both counters 0.
  - in_ready=0 while rst is high; it evaluates normally from the first cycle after rst is released.

Test Plan:
- Reset then add (op 00, funct 20, rs=5, rt=7, rd=3), ex_ready=1 -> next cycle: ex_valid=1, alu_op=0000, in1=5, in2=7, dest=3, reg_write=1, issued_cnt=1 after transfer.
- sll shamt=4, rt_data=1; then sllv with rs_data=0x25 -> in1=4, op=0111; then in1=5 (masked), op=0111.
- addi imm=FFFF -> in2=FFFFFFFF; ori imm=FFFF -> in2=0000FFFF; lui imm=1234 -> op=1000, in1=00001234, in2=16.
- Stall: ex_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs frozen; ex_ready=1 -> next instruction loads the following cycle, nothing lost or duplicated.
- Flush while holding a stalled instruction with in_valid=1 -> ex_valid=0 next cycle, incoming not accepted, issued_cnt unchanged.
- opcode 3F -> illegal=1, alu_op=0010, reg_write=0, illegal_cnt=1; addu to rd=0 -> reg_write=0.

Source files
------------

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage for the MIPS ALU.
// Decodes opcode/funct into the 4-bit ALU OP code, prepares both operands
// (shamt placement, immediate extension, variable shift-amount masking) and
// registers the result behind a valid/ready handshake with stall and flush.
//
// Handshake: a transfer happens on any rising edge where valid and ready are
// both high. The upstream side (in_valid/in_ready) loads a new instruction on
// in_valid & in_ready. The downstream side (ex_valid/ex_ready) presents the
// registered instruction; while ex_valid is high and ex_ready is low, every EX
// output holds stable. in_ready never depends on in_valid, and flush forces
// in_ready low and drops whatever is held.
module alu_issue_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic [4:0]       shamt,
  input  logic [4:0]       rt_idx,
  input  logic [4:0]       rd_idx,
  input  logic [15:0]      imm16,
  input  logic [31:0]      rs_data,
  input  logic [31:0]      rt_data,
  input  logic             flush,
  output logic             ex_valid,
  input  logic             ex_ready,
  output logic [3:0]       alu_op,
  output logic [31:0]      alu_in1,
  output logic [31:0]      alu_in2,
  output logic [4:0]       dest_reg,
  output logic             reg_write,
  output logic             illegal,
  output logic [CNT_W-1:0] issued_cnt,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_ILL  = 4'b0010;
  localparam logic [3:0] OP_AND  = 4'b0011;
  localparam logic [3:0] OP_NOR  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_SLLR = 4'b0111; // In2 << In1
  localparam logic [3:0] OP_SLLI = 4'b1000; // In1 << In2
  localparam logic [3:0] OP_SRLR = 4'b1001; // In2 >> In1
  localparam logic [3:0] OP_SLT  = 4'b1110;
  localparam logic [3:0] OP_SLTU = 4'b1111;

  logic [3:0]  op_d;
  logic [31:0] in1_d;
  logic [31:0] in2_d;
  logic [4:0]  dest_d;
  logic        ill_d;
  logic        rw_d;
  logic [31:0] imm_sext;
  logic [31:0] imm_zext;
  logic        load;
  logic        xfer;

  assign imm_sext = {{16{imm16[15]}}, imm16};
  assign imm_zext = {16'b0, imm16};

  // Upstream may hand over when the output slot is empty or being drained.
  assign in_ready = !rst && !flush && (!ex_valid || ex_ready);
  assign load     = in_valid && in_ready;
  assign xfer     = ex_valid && ex_ready && !flush;

  // Decode opcode/funct into OP code, operands and destination.
  // Illegal instructions carry OP 0010, zero operands and dest 0.
  always_comb begin
    op_d   = OP_ILL;
    in1_d  = 32'b0;
    in2_d  = 32'b0;
    dest_d = 5'd0;
    ill_d  = 1'b0;
    if (opcode == 6'h00) begin
      in1_d  = rs_data;
      in2_d  = rt_data;
      dest_d = rd_idx;
      case (funct)
        6'h20, 6'h21: op_d = OP_ADD;
        6'h22, 6'h23: op_d = OP_SUB;
        6'h24:        op_d = OP_AND;
        6'h25:        op_d = OP_OR;
        6'h26:        op_d = OP_XOR;
        6'h27:        op_d = OP_NOR;
        6'h2A:        op_d = OP_SLT;
        6'h2B:        op_d = OP_SLTU;
        6'h00: begin op_d = OP_SLLR; in1_d = {27'b0, shamt}; end
        6'h02: begin op_d = OP_SRLR; in1_d = {27'b0, shamt}; end
        6'h04: begin op_d = OP_SLLR; in1_d = {27'b0, rs_data[4:0]}; end
        6'h06: begin op_d = OP_SRLR; in1_d = {27'b0, rs_data[4:0]}; end
        default:      ill_d = 1'b1;
      endcase
    end else begin
      in1_d  = rs_data;
      dest_d = rt_idx;
      case (opcode)
        6'h08, 6'h09: begin op_d = OP_ADD;  in2_d = imm_sext; end
        6'h0A:        begin op_d = OP_SLT;  in2_d = imm_sext; end
        6'h0B:        begin op_d = OP_SLTU; in2_d = imm_sext; end
        6'h0C:        begin op_d = OP_AND;  in2_d = imm_zext; end
        6'h0D:        begin op_d = OP_OR;   in2_d = imm_zext; end
        6'h0E:        begin op_d = OP_XOR;  in2_d = imm_zext; end
        6'h0F:        begin op_d = OP_SLLI; in1_d = imm_zext; in2_d = 32'd16; end
        default:      ill_d = 1'b1;
      endcase
    end
    if (ill_d) begin
      op_d   = OP_ILL;
      in1_d  = 32'b0;
      in2_d  = 32'b0;
      dest_d = 5'd0;
    end
  end

  assign rw_d = !ill_d && (dest_d != 5'd0);

  // Output slot: valid bit, payload captured on load, transfer counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid    <= 1'b0;
      alu_op      <= OP_ADD;
      alu_in1     <= 32'b0;
      alu_in2     <= 32'b0;
      dest_reg    <= 5'd0;
      reg_write   <= 1'b0;
      illegal     <= 1'b0;
      issued_cnt  <= '0;
      illegal_cnt <= '0;
    end else begin
      if (flush)         ex_valid <= 1'b0;
      else if (load)     ex_valid <= 1'b1;
      else if (ex_ready) ex_valid <= 1'b0;
      if (load) begin
        alu_op    <= op_d;
        alu_in1   <= in1_d;
        alu_in2   <= in2_d;
        dest_reg  <= dest_d;
        reg_write <= rw_d;
        illegal   <= ill_d;
      end
      if (xfer) begin
        issued_cnt <= issued_cnt + 1'b1;
        if (illegal) illegal_cnt <= illegal_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: table of decode vectors, then
// hand-written stall, flush and reset-mid-transfer sequences.
module tb_alu_issue_stage;

  localparam int CNT_W = 16;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic [4:0]       shamt;
  logic [4:0]       rt_idx;
  logic [4:0]       rd_idx;
  logic [15:0]      imm16;
  logic [31:0]      rs_data;
  logic [31:0]      rt_data;
  logic             flush;
  logic             ex_valid;
  logic             ex_ready;
  logic [3:0]       alu_op;
  logic [31:0]      alu_in1;
  logic [31:0]      alu_in2;
  logic [4:0]       dest_reg;
  logic             reg_write;
  logic             illegal;
  logic [CNT_W-1:0] issued_cnt;
  logic [CNT_W-1:0] illegal_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [4:0]  rt_idx;
    logic [4:0]  rd_idx;
    logic [15:0] imm16;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [3:0]  op;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [4:0]  dest;
    logic        rw;
    logic        ill;
  } vec_t;

  vec_t vecs[$];

  alu_issue_stage #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct(funct), .shamt(shamt), .rt_idx(rt_idx),
    .rd_idx(rd_idx), .imm16(imm16), .rs_data(rs_data), .rt_data(rt_data),
    .flush(flush), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .alu_op(alu_op), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .dest_reg(dest_reg), .reg_write(reg_write), .illegal(illegal),
    .issued_cnt(issued_cnt), .illegal_cnt(illegal_cnt)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic [5:0] op6, input logic [5:0] fn, input logic [4:0] sh,
    input logic [4:0] rt_i, input logic [4:0] rd_i, input logic [15:0] imm,
    input logic [31:0] rs, input logic [31:0] rt,
    input logic [3:0] e_op, input logic [31:0] e_in1, input logic [31:0] e_in2,
    input logic [4:0] e_dest, input logic e_rw, input logic e_ill);
    vec_t v;
    v.opcode = op6; v.funct = fn; v.shamt = sh; v.rt_idx = rt_i;
    v.rd_idx = rd_i; v.imm16 = imm; v.rs_data = rs; v.rt_data = rt;
    v.op = e_op; v.in1 = e_in1; v.in2 = e_in2; v.dest = e_dest;
    v.rw = e_rw; v.ill = e_ill;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_vec(input vec_t v);
    opcode  = v.opcode;
    funct   = v.funct;
    shamt   = v.shamt;
    rt_idx  = v.rt_idx;
    rd_idx  = v.rd_idx;
    imm16   = v.imm16;
    rs_data = v.rs_data;
    rt_data = v.rt_data;
  endtask

  // Bounded wait for in_ready; a timeout shows up as a failed check.
  task automatic wait_ready();
    for (int k = 0; k < 20 && !in_ready; k++) begin
      @(posedge clk); #1;
    end
    chk("in_ready_wait", in_ready, 1);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; ex_ready = 1'b1;
    opcode = '0; funct = '0; shamt = '0; rt_idx = '0; rd_idx = '0;
    imm16 = '0; rs_data = '0; rt_data = '0;

    // Decode table: inputs and hand-computed expected outputs.
    vecs.push_back(mk(6'h00, 6'h20, 5'd0, 5'd7, 5'd3, 16'h0, 32'd5, 32'd7, 4'b0000, 32'd5, 32'd7, 5'd3, 1, 0));
    vecs.push_back(mk(6'h00, 6'h22, 5'd0, 5'd1, 5'd4, 16'h0, 32'd10, 32'd3, 4'b0001, 32'd10, 32'd3, 5'd4, 1, 0));
    vecs.push_back(mk(6'h00, 6'h24, 5'd0, 5'd1, 5'd5, 16'h0, 32'hF0F0F0F0, 32'hFF00FF00, 4'b0011, 32'hF0F0F0F0, 32'hFF00FF00, 5'd5, 1, 0));
    vecs.push_back(mk(6'h00, 6'h25, 5'd0, 5'd1, 5'd6, 16'h0, 32'h1, 32'h2, 4'b0101, 32'h1, 32'h2, 5'd6, 1, 0));
    vecs.push_back(mk(6'h00, 6'h26, 5'd0, 5'd1, 5'd7, 16'h0, 32'h3, 32'h4, 4'b0110, 32'h3, 32'h4, 5'd7, 1, 0));
    vecs.push_back(mk(6'h00, 6'h27, 5'd0, 5'd1, 5'd8, 16'h0, 32'h5, 32'h6, 4'b0100, 32'h5, 32'h6, 5'd8, 1, 0));
    vecs.push_back(mk(6'h00, 6'h2A, 5'd0, 5'd1, 5'd9, 16'h0, 32'hFFFFFFFF, 32'h1, 4'b1110, 32'hFFFFFFFF, 32'h1, 5'd9, 1, 0));
    vecs.push_back(mk(6'h00, 6'h2B, 5'd0, 5'd1, 5'd10, 16'h0, 32'hFFFFFFFF, 32'h1, 4'b1111, 32'hFFFFFFFF, 32'h1, 5'd10, 1, 0));
    vecs.push_back(mk(6'h00, 6'h23, 5'd0, 5'd1, 5'd11, 16'h0, 32'h9, 32'h2, 4'b0001, 32'h9, 32'h2, 5'd11, 1, 0));
    vecs.push_back(mk(6'h00, 6'h00, 5'd4, 5'd2, 5'd12, 16'h0, 32'hDEAD, 32'h1, 4'b0111, 32'd4, 32'h1, 5'd12, 1, 0));
    vecs.push_back(mk(6'h00, 6'h04, 5'd0, 5'd2, 5'd13, 16'h0, 32'h25, 32'h1, 4'b0111, 32'd5, 32'h1, 5'd13, 1, 0));
    vecs.push_back(mk(6'h00, 6'h02, 5'd31, 5'd0, 5'd14, 16'h0, 32'h0, 32'h80000000, 4'b1001, 32'd31, 32'h80000000, 5'd14, 1, 0));
    vecs.push_back(mk(6'h00, 6'h06, 5'd0, 5'd0, 5'd15, 16'h0, 32'hFFFFFFE3, 32'h80000000, 4'b1001, 32'd3, 32'h80000000, 5'd15, 1, 0));
    vecs.push_back(mk(6'h08, 6'h00, 5'd0, 5'd9, 5'd0, 16'hFFFF, 32'd10, 32'h0, 4'b0000, 32'd10, 32'hFFFFFFFF, 5'd9, 1, 0));
    vecs.push_back(mk(6'h0D, 6'h00, 5'd0, 5'd16, 5'd0, 16'hFFFF, 32'h100, 32'h0, 4'b0101, 32'h100, 32'h0000FFFF, 5'd16, 1, 0));
    vecs.push_back(mk(6'h0A, 6'h00, 5'd0, 5'd17, 5'd0, 16'h8000, 32'd5, 32'h0, 4'b1110, 32'd5, 32'hFFFF8000, 5'd17, 1, 0));
    vecs.push_back(mk(6'h0B, 6'h00, 5'd0, 5'd18, 5'd0, 16'h7FFF, 32'd5, 32'h0, 4'b1111, 32'd5, 32'h00007FFF, 5'd18, 1, 0));
    vecs.push_back(mk(6'h0C, 6'h00, 5'd0, 5'd19, 5'd0, 16'h8000, 32'h7, 32'h0, 4'b0011, 32'h7, 32'h00008000, 5'd19, 1, 0));
    vecs.push_back(mk(6'h0E, 6'h00, 5'd0, 5'd20, 5'd0, 16'h0001, 32'h7, 32'h0, 4'b0110, 32'h7, 32'h00000001, 5'd20, 1, 0));
    vecs.push_back(mk(6'h0F, 6'h00, 5'd0, 5'd21, 5'd0, 16'h1234, 32'hABCD, 32'h0, 4'b1000, 32'h00001234, 32'd16, 5'd21, 1, 0));
    vecs.push_back(mk(6'h09, 6'h00, 5'd0, 5'd0, 5'd0, 16'h0001, 32'd3, 32'h0, 4'b0000, 32'd3, 32'd1, 5'd0, 0, 0));
    vecs.push_back(mk(6'h00, 6'h21, 5'd0, 5'd4, 5'd0, 16'h0, 32'd1, 32'd2, 4'b0000, 32'd1, 32'd2, 5'd0, 0, 0));
    vecs.push_back(mk(6'h3F, 6'h20, 5'd0, 5'd3, 5'd4, 16'h0, 32'd5, 32'd6, 4'b0010, 32'd0, 32'd0, 5'd0, 0, 1));
    vecs.push_back(mk(6'h00, 6'h3F, 5'd0, 5'd3, 5'd4, 16'h0, 32'd5, 32'd6, 4'b0010, 32'd0, 32'd0, 5'd0, 0, 1));
    vecs.push_back(mk(6'h02, 6'h00, 5'd0, 5'd3, 5'd4, 16'h0, 32'd5, 32'd6, 4'b0010, 32'd0, 32'd0, 5'd0, 0, 1));

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_alu_in1", alu_in1, 0);
    chk("rst_alu_in2", alu_in2, 0);
    chk("rst_dest", dest_reg, 0);
    chk("rst_reg_write", reg_write, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_issued_cnt", issued_cnt, 0);
    chk("rst_illegal_cnt", illegal_cnt, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    // Table: back-to-back issue with ex_ready held high
    for (int i = 0; i < vecs.size(); i++) begin
      drive_vec(vecs[i]);
      in_valid = 1'b1;
      wait_ready();
      step();
      chk($sformatf("v%0d_ex_valid", i), ex_valid, 1);
      chk($sformatf("v%0d_alu_op", i), alu_op, vecs[i].op);
      chk($sformatf("v%0d_alu_in1", i), alu_in1, vecs[i].in1);
      chk($sformatf("v%0d_alu_in2", i), alu_in2, vecs[i].in2);
      chk($sformatf("v%0d_dest", i), dest_reg, vecs[i].dest);
      chk($sformatf("v%0d_reg_write", i), reg_write, vecs[i].rw);
      chk($sformatf("v%0d_illegal", i), illegal, vecs[i].ill);
    end
    in_valid = 1'b0;
    step();
    chk("tbl_drain_ex_valid", ex_valid, 0);
    chk("tbl_issued_cnt", issued_cnt, 25);
    chk("tbl_illegal_cnt", illegal_cnt, 3);

    // Stall: A held for 3 cycles while B waits, then both drain in order
    ex_ready = 1'b0;
    drive_vec(mk(6'h00, 6'h20, 5'd0, 5'd2, 5'd5, 16'h0, 32'd1, 32'd2, 4'b0000, 32'd1, 32'd2, 5'd5, 1, 0));
    exp_q.push_back(32'd1);
    in_valid = 1'b1;
    wait_ready();
    step();
    drive_vec(mk(6'h00, 6'h22, 5'd0, 5'd4, 5'd6, 16'h0, 32'd9, 32'd4, 4'b0001, 32'd9, 32'd4, 5'd6, 1, 0));
    exp_q.push_back(32'd9);
    for (int c = 0; c < 3; c++) begin
      chk("stall_in_ready", in_ready, 0);
      chk("stall_ex_valid", ex_valid, 1);
      chk("stall_alu_in1", alu_in1, exp_q[0]);
      chk("stall_alu_op", alu_op, 4'b0000);
      chk("stall_issued_cnt", issued_cnt, 25);
      step();
    end
    ex_ready = 1'b1;
    #1;
    chk("unstall_in_ready", in_ready, 1);
    step();
    void'(exp_q.pop_front());
    chk("stall_b_alu_in1", alu_in1, exp_q[0]);
    chk("stall_b_alu_op", alu_op, 4'b0001);
    chk("stall_b_ex_valid", ex_valid, 1);
    chk("stall_a_issued_cnt", issued_cnt, 26);
    in_valid = 1'b0;
    step();
    void'(exp_q.pop_front());
    chk("stall_b_issued_cnt", issued_cnt, 27);
    chk("stall_drain_ex_valid", ex_valid, 0);
    chk("stall_queue_empty", exp_q.size(), 0);

    // Flush while holding C, with D offered and ex_ready raised in the same cycle
    ex_ready = 1'b0;
    drive_vec(mk(6'h00, 6'h25, 5'd0, 5'd5, 5'd7, 16'h0, 32'd3, 32'd5, 4'b0101, 32'd3, 32'd5, 5'd7, 1, 0));
    in_valid = 1'b1;
    wait_ready();
    step();
    chk("flush_c_ex_valid", ex_valid, 1);
    drive_vec(mk(6'h00, 6'h26, 5'd0, 5'd5, 5'd8, 16'h0, 32'd7, 32'd5, 4'b0110, 32'd7, 32'd5, 5'd8, 1, 0));
    flush = 1'b1;
    ex_ready = 1'b1;
    #1;
    chk("flush_in_ready", in_ready, 0);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_ex_valid", ex_valid, 0);
    chk("flush_issued_cnt", issued_cnt, 27);
    step();
    chk("flush_no_load", ex_valid, 0);
    chk("flush_issued_cnt2", issued_cnt, 27);

    // Issue resumes normally after the flush
    drive_vec(mk(6'h00, 6'h22, 5'd0, 5'd8, 5'd2, 16'h0, 32'd20, 32'd8, 4'b0001, 32'd20, 32'd8, 5'd2, 1, 0));
    in_valid = 1'b1;
    wait_ready();
    step();
    in_valid = 1'b0;
    chk("resume_alu_op", alu_op, 4'b0001);
    chk("resume_alu_in1", alu_in1, 32'd20);
    step();
    chk("resume_issued_cnt", issued_cnt, 28);

    // Reset while an illegal instruction is mid-transfer
    drive_vec(mk(6'h3F, 6'h00, 5'd0, 5'd1, 5'd1, 16'h0, 32'd1, 32'd1, 4'b0010, 32'd0, 32'd0, 5'd0, 0, 1));
    in_valid = 1'b1;
    wait_ready();
    step();
    in_valid = 1'b0;
    chk("mid_ill_illegal", illegal, 1);
    chk("mid_ill_alu_op", alu_op, 4'b0010);
    rst = 1'b1;
    step();
    chk("mid_rst_ex_valid", ex_valid, 0);
    chk("mid_rst_illegal", illegal, 0);
    chk("mid_rst_alu_op", alu_op, 0);
    chk("mid_rst_issued_cnt", issued_cnt, 0);
    chk("mid_rst_illegal_cnt", illegal_cnt, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    rst = 1'b0;
    #1;
    chk("mid_rst_release_ready", in_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
